// File: rtl/xmii_elastic_buffer_pkg.sv
// Shared definitions for the xMII elastic buffer: read FSM encodings,
// write-request kinds and the stored entry layout.
package xmii_elastic_buffer_pkg;

   localparam logic [0:0] RD_IDLE  = 1'b0;
   localparam logic [0:0] RD_FRAME = 1'b1;

   typedef enum logic [1:0] {
      WR_NONE,
      WR_DATA,
      WR_MARK
   } wr_req_t;

   // Entry = {eof, er, d[width-1:0]}
   function automatic int entry_width(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/xmii_elastic_mem.sv
// Entry storage for the elastic buffer: one write port, one asynchronous read
// port, and an er-bit force used to flag a frame truncated by overflow.
module xmii_elastic_mem
   import xmii_elastic_buffer_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             wr_en,
   input  logic [$clog2(DEPTH)-1:0]         wr_addr,
   input  logic [entry_width(WIDTH)-1:0]    wr_data,
   input  logic [$clog2(DEPTH)-1:0]         rd_addr,
   output logic [entry_width(WIDTH)-1:0]    rd_data,
   input  logic                             er_force,
   input  logic [$clog2(DEPTH)-1:0]         er_addr
);

   logic [entry_width(WIDTH)-1:0] mem [DEPTH];

   // NOTE: the array has no reset; the level counter gates every read, so
   // stale contents are never observed. Sequential state uses <= so all
   // registers sample the pre-edge values.
   always_ff @(posedge clk) begin
      if (er_force) mem[er_addr][WIDTH] <= 1'b1;
      if (wr_en)    mem[wr_addr]        <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xmii_elastic_buffer.sv
// Pointer-based elastic buffer repeating MII/GMII frames between two clock-enable
// domains; stores frame data plus one end marker, re-centring on WATERMARK between frames.
module xmii_elastic_buffer
   import xmii_elastic_buffer_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 8,
   parameter int WATERMARK = DEPTH / 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tx_ce,
   input  logic                     tx_en,
   input  logic                     tx_er,
   input  logic [WIDTH-1:0]         txd,
   input  logic                     rx_ce,
   output logic                     rx_dv,
   output logic                     rx_er,
   output logic [WIDTH-1:0]         rxd,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int            AW    = $clog2(DEPTH);
   localparam int            EW    = entry_width(WIDTH);
   localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   WMARK = (AW+1)'(WATERMARK);

   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [0:0]       rd_state, nxt_state;
   logic             in_frame, has_data, dropping, pend_mark;
   logic [EW-1:0]    head, wr_data;
   logic             head_valid, head_eof;
   logic             pop, push, room, data_reject, er_force, under_evt;
   logic             nxt_dv, nxt_er;
   logic [WIDTH-1:0] nxt_d;
   wr_req_t          wr_req;

   assign head_valid = (level != '0);
   assign head_eof   = head[EW-1];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pop       = 1'b0;
      under_evt = 1'b0;
      nxt_state = rd_state;
      nxt_dv    = 1'b0;
      nxt_er    = 1'b0;
      nxt_d     = '0;
      if (rx_ce) begin
         if (rd_state == RD_IDLE) begin
            if (head_valid && head_eof) begin
               pop = 1'b1;
            end else if (head_valid && level >= WMARK) begin
               pop       = 1'b1;
               nxt_dv    = 1'b1;
               nxt_er    = head[WIDTH];
               nxt_d     = head[WIDTH-1:0];
               nxt_state = RD_FRAME;
            end
         end else if (!head_valid) begin
            nxt_dv    = 1'b1;
            nxt_er    = 1'b1;
            under_evt = 1'b1;
         end else if (head_eof) begin
            pop       = 1'b1;
            nxt_state = RD_IDLE;
         end else begin
            pop    = 1'b1;
            nxt_dv = 1'b1;
            nxt_er = head[WIDTH];
            nxt_d  = head[WIDTH-1:0];
         end
      end
   end

   // A pending marker outranks new data; a frame that stored nothing gets no marker.
   always_comb begin
      wr_req = WR_NONE;
      if (pend_mark || (tx_ce && !tx_en && in_frame && has_data))
         wr_req = WR_MARK;
      else if (tx_ce && tx_en && !dropping)
         wr_req = WR_DATA;
   end

   assign room        = (level != FULL) || pop;
   assign push        = (wr_req != WR_NONE) && room;
   assign data_reject = tx_ce && tx_en && !dropping && !((wr_req == WR_DATA) && room);
   assign er_force    = data_reject && has_data;
   assign wr_data     = (wr_req == WR_MARK) ? {1'b1, 1'b0, {WIDTH{1'b0}}}
                                            : {1'b0, tx_er, txd};

   xmii_elastic_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk      (clk),
      .wr_en    (push && !rst),
      .wr_addr  (wr_ptr),
      .wr_data  (wr_data),
      .rd_addr  (rd_ptr),
      .rd_data  (head),
      .er_force (er_force && !rst),
      .er_addr  (wr_ptr - AW'(1))
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         rd_state  <= RD_IDLE;
         in_frame  <= 1'b0;
         has_data  <= 1'b0;
         dropping  <= 1'b0;
         pend_mark <= 1'b0;
         rx_dv     <= 1'b0;
         rx_er     <= 1'b0;
         rxd       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
         if (wr_req == WR_MARK) pend_mark <= !room;
         if (tx_ce) begin
            if (tx_en) begin
               in_frame <= 1'b1;
               if ((wr_req == WR_DATA) && room) has_data <= 1'b1;
               if (data_reject) dropping <= 1'b1;
            end else begin
               in_frame <= 1'b0;
               has_data <= 1'b0;
               dropping <= 1'b0;
            end
         end
         rd_state  <= nxt_state;
         overflow  <= data_reject;
         underflow <= under_evt;
         if (rx_ce) begin
            rx_dv <= nxt_dv;
            rx_er <= nxt_er;
            rxd   <= nxt_d;
         end
      end
   end

endmodule

// File: tb/tb_xmii_elastic_buffer.sv
// Self-checking bench for xmii_elastic_buffer: a queue-based model checked every
// cycle, directed frame scenarios with literal expectations, then random traffic.
module tb_xmii_elastic_buffer;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int WM    = 4;

   logic       clk = 1'b0, rst = 1'b1;
   logic       tx_ce = 1'b0, tx_en = 1'b0, tx_er = 1'b0, rx_ce = 1'b0;
   logic [3:0] txd = '0;
   logic       rx_dv, rx_er, overflow, underflow;
   logic [3:0] rxd;
   logic [3:0] level;

   xmii_elastic_buffer #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .WATERMARK (WM)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tx_ce     (tx_ce),
      .tx_en     (tx_en),
      .tx_er     (tx_er),
      .txd       (txd),
      .rx_ce     (rx_ce),
      .rx_dv     (rx_dv),
      .rx_er     (rx_er),
      .rxd       (rxd),
      .level     (level),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int ov_cnt = 0, un_cnt = 0;
   int got[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the buffer is a queue of {eof, er, d} entries.
   typedef struct packed {logic eof; logic er; logic [3:0] d;} ent_t;
   ent_t q[$];
   bit   m_in_frame = 0, m_has_data = 0, m_drop = 0, m_pend = 0, m_frame_rd = 0;
   bit   m_dv = 0, m_er = 0, m_ov = 0, m_un = 0, m_rce = 0;
   logic [3:0] m_d = '0;
   int   m_level = 0;

   always @(posedge clk) begin
      int   n;
      bit   pop_it, room, want_mark, took_data, rej;
      ent_t t;
      m_ov  = 0;
      m_un  = 0;
      m_rce = 0;
      if (rst) begin
         q.delete();
         m_in_frame = 0; m_has_data = 0; m_drop = 0; m_pend = 0; m_frame_rd = 0;
         m_dv = 0; m_er = 0; m_d = '0;
      end else begin
         n      = q.size();
         pop_it = 0;
         m_rce  = rx_ce;
         if (rx_ce) begin
            if (!m_frame_rd) begin
               m_dv = 0; m_er = 0; m_d = '0;
               if (n > 0 && q[0].eof) pop_it = 1;
               else if (n > 0 && n >= WM) begin
                  pop_it = 1; m_dv = 1; m_er = q[0].er; m_d = q[0].d; m_frame_rd = 1;
               end
            end else if (n == 0) begin
               m_dv = 1; m_er = 1; m_d = '0; m_un = 1;
            end else if (q[0].eof) begin
               pop_it = 1; m_dv = 0; m_er = 0; m_d = '0; m_frame_rd = 0;
            end else begin
               pop_it = 1; m_dv = 1; m_er = q[0].er; m_d = q[0].d;
            end
         end
         room      = (n < DEPTH) || pop_it;
         want_mark = m_pend || (tx_ce && !tx_en && m_in_frame && m_has_data);
         took_data = !want_mark && tx_ce && tx_en && !m_drop && room;
         rej       = tx_ce && tx_en && !m_drop && !took_data;
         if (rej && m_has_data) begin
            t = q[$]; t.er = 1'b1; q[$] = t;
         end
         if (pop_it) void'(q.pop_front());
         if (want_mark && room) q.push_back({1'b1, 1'b0, 4'h0});
         if (took_data) q.push_back({1'b0, tx_er, txd});
         if (want_mark) m_pend = !room;
         m_ov = rej;
         if (tx_ce) begin
            if (tx_en) begin
               m_in_frame = 1;
               if (took_data) m_has_data = 1;
               if (rej) m_drop = 1;
            end else begin
               m_in_frame = 0; m_has_data = 0; m_drop = 0;
            end
         end
      end
      m_level = q.size();
   end

   always @(negedge clk) begin
      check("rx_dv", rx_dv, m_dv);
      check("rx_er", rx_er, m_er);
      check("rxd", rxd, m_d);
      check("level", level, m_level);
      check("overflow", overflow, m_ov);
      check("underflow", underflow, m_un);
      if (m_rce && rx_dv === 1'b1) got.push_back(int'({rx_er, rxd}));
      if (overflow === 1'b1)  ov_cnt++;
      if (underflow === 1'b1) un_cnt++;
   end

   task automatic step(input bit tce, input bit ten, input bit ter, input logic [3:0] d, input bit rce);
      tx_ce = tce; tx_en = ten; tx_er = ter; txd = d; rx_ce = rce;
      @(negedge clk);
      #1;
      cyc++;
   endtask

   function automatic bit rce_at(input int mode);
      if (mode > 0) return (cyc % mode) == 0;
      return (cyc % 8) != 7;
   endfunction

   task automatic clear_logs();
      got.delete();
      ov_cnt = 0;
      un_cnt = 0;
   endtask

   task automatic send_frame(input int len, input int first, input int tx_per, input int rx_mode, input int gap);
      int s;
      bit tce;
      s = 0;
      while (s < len + gap) begin
         tce = (cyc % tx_per) == 0;
         step(tce, s < len, 1'b0, 4'((first + s) % 16), rce_at(rx_mode));
         if (tce) s++;
      end
   endtask

   task automatic drain(input int n, input int rx_mode);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, rce_at(rx_mode));
   endtask

   initial begin
      int nd, nf, n;
      bit ten, ter, tce, rce;
      int tx_p, rx_p;

      step(0, 0, 0, 4'h0, 0);
      step(0, 0, 0, 4'h0, 0);
      rst = 1'b0;

      // Equal rates, 16-nibble frame
      clear_logs();
      for (int i = 0; i < 16; i++) begin
         step(1, 1, 0, 4'(i), 1);
         if (i == 3) begin
            check("t1_dv_below_wm", rx_dv, 0);
            check("t1_level_at_wm", level, 4);
         end
         if (i == 4) begin
            check("t1_dv_at_wm", rx_dv, 1);
            check("t1_first_rxd", rxd, 0);
         end
      end
      step(1, 0, 0, 4'h0, 1);
      step(1, 0, 0, 4'h0, 1);
      drain(20, 1);
      check("t1_count", got.size(), 16);
      for (int i = 0; i < got.size() && i < 16; i++) check("t1_sym", got[i], i);
      check("t1_ovf", ov_cnt, 0);
      check("t1_unf", un_cnt, 0);
      check("t1_level_end", level, 0);

      // Slow writer: underflow fillers
      clear_logs();
      send_frame(20, 0, 2, 1, 2);
      drain(40, 1);
      nd = 0; nf = 0;
      foreach (got[i]) begin
         if (got[i] == 16) nf++;
         else begin
            check("t2_sym", got[i], nd % 16);
            nd++;
         end
      end
      check("t2_data_count", nd, 20);
      check("t2_underflow_seen", un_cnt > 0, 1);
      check("t2_fill_matches_underflow", nf, un_cnt);
      check("t2_ovf", ov_cnt, 0);
      check("t2_dv_end", rx_dv, 0);

      // Slow reader: one overflow, truncated frame flagged, next frame clean
      clear_logs();
      send_frame(20, 0, 1, 3, 2);
      drain(60, 3);
      n = got.size();
      check("t3_ovf_once", ov_cnt, 1);
      check("t3_truncated", (n > 0) && (n < 20), 1);
      for (int i = 0; i < n - 1; i++) check("t3_sym", got[i], i % 16);
      if (n > 0) check("t3_last_er", got[n-1], 16 + ((n - 1) % 16));
      clear_logs();
      send_frame(6, 5, 1, 3, 2);
      drain(40, 3);
      check("t3_next_count", got.size(), 6);
      for (int i = 0; i < got.size() && i < 6; i++) check("t3_next_sym", got[i], 5 + i);
      check("t3_next_ovf", ov_cnt, 0);

      // Back-to-back frames, reader 7/8 of writer rate
      clear_logs();
      send_frame(12, 0, 1, -1, 2);
      send_frame(12, 3, 1, -1, 2);
      drain(40, -1);
      check("t4_count", got.size(), 24);
      for (int i = 0; i < got.size() && i < 24; i++)
         check("t4_sym", got[i], (i < 12) ? i : (i - 12 + 3));
      check("t4_ovf", ov_cnt, 0);
      check("t4_unf", un_cnt, 0);

      // False carrier is never stored
      clear_logs();
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 1, 4'(i), 1);
         check("t5_level", level, 0);
         check("t5_dv", rx_dv, 0);
      end
      check("t5_count", got.size(), 0);

      // Reset mid-frame at level 5
      for (int i = 0; i < 5; i++) step(1, 1, 0, 4'(i), 0);
      check("t6_level_pre", level, 5);
      step(1, 1, 0, 4'h5, 1);
      step(1, 1, 0, 4'h6, 1);
      check("t6_dv_pre", rx_dv, 1);
      check("t6_level_hold", level, 5);
      rst = 1'b1;
      step(1, 1, 0, 4'h7, 1);
      rst = 1'b0;
      check("t6_level_rst", level, 0);
      check("t6_dv_rst", rx_dv, 0);
      check("t6_er_rst", rx_er, 0);
      check("t6_rxd_rst", rxd, 0);
      step(0, 0, 0, 4'h0, 1);
      clear_logs();
      send_frame(8, 9, 1, 1, 2);
      drain(20, 1);
      check("t6_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++) check("t6_sym", got[i], (9 + i) % 16);

      // Random traffic against the model
      ten = 0;
      for (int seg = 0; seg < 12; seg++) begin
         tx_p = (seg % 4 == 0) ? 100 : $urandom_range(40, 100);
         rx_p = (seg % 4 == 1) ? 100 : $urandom_range(30, 100);
         for (int i = 0; i < 250; i++) begin
            tce = $urandom_range(0, 99) < tx_p;
            rce = $urandom_range(0, 99) < rx_p;
            if (tce) begin
               if (ten) ten = $urandom_range(0, 15) != 0;
               else     ten = $urandom_range(0, 3) == 0;
            end
            ter = $urandom_range(0, 19) == 0;
            rst = ($urandom_range(0, 599) == 0);
            step(tce, ten, ter, 4'($urandom_range(0, 15)), rce);
            rst = 1'b0;
         end
      end
      drain(40, 1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
